// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- groups the CPU instruction port, CPU data port and the
// unified memory port of mem_arbiter into a single bundle.
//   master : arbiter view (accepts CPU requests, drives the memory request,
//            forwards memory responses back to the CPU)
//   slave  : environment view (CPU core plus memory model)
// Signal names match the original flat port list of mem_arbiter.
interface mem_arbiter_if;
  // CPU instruction channel
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  // CPU data channel
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  // Unified memory port
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;

  modport master (
    input  PC, Inst_Req_Valid, Inst_Ready,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output Inst_Req_Ready, Instruction, Inst_Valid,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_resp_ready
  );

  modport slave (
    output PC, Inst_Req_Valid, Inst_Ready,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  Inst_Req_Ready, Instruction, Inst_Valid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_resp_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a CPU instruction-fetch port and a CPU data port
// onto one memory port with at most one transaction outstanding. Data
// requests have fixed priority over instruction fetches. Writes complete on
// the request handshake; reads wait for one response, which is returned only
// to the channel that issued it.
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   bus           mem_arbiter_if.master (CPU inst/data channels, memory port)
//   arb_inst_wait instruction-channel stall counter
//   arb_data_wait data-channel stall counter
// Build option: define ARB_PERF_CNT_EN to enable the stall counters; when it
// is undefined both counter outputs are tied to zero and no counter
// registers are built.
module mem_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.master        bus,
  output logic [31:0]          arb_inst_wait,
  output logic [31:0]          arb_data_wait
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        data_req;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        inst_req_ready;
  logic        data_req_ready;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        resp_ready;

  assign data_req = bus.MemRead | bus.MemWrite;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_wen        = 1'b0;
    req_wdata      = '0;
    req_wstrb      = '0;
    inst_req_ready = 1'b0;
    data_req_ready = 1'b0;
    inst_valid     = 1'b0;
    inst_data      = '0;
    rd_valid       = 1'b0;
    rd_data        = '0;
    resp_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        // Nothing is outstanding, so any stray response is accepted and dropped.
        resp_ready = 1'b1;
        req_valid  = bus.Inst_Req_Valid | data_req;
        if (data_req) begin
          req_addr       = bus.Address;
          req_wen        = bus.MemWrite;
          req_wdata      = bus.Write_data;
          req_wstrb      = bus.Write_strb;
          data_req_ready = bus.mem_req_ready;
          // A write has no response phase; stay in IDLE after it is accepted.
          if (bus.mem_req_ready) begin
            state_d = bus.MemWrite ? IDLE : WAIT_D;
          end
        end else if (bus.Inst_Req_Valid) begin
          req_addr       = bus.PC;
          inst_req_ready = bus.mem_req_ready;
          if (bus.mem_req_ready) begin
            state_d = WAIT_I;
          end
        end
      end
      WAIT_I: begin
        inst_valid = bus.mem_resp_valid;
        inst_data  = bus.mem_resp_data;
        resp_ready = bus.Inst_Ready;
        if (bus.mem_resp_valid && bus.Inst_Ready) begin
          state_d = IDLE;
        end
      end
      WAIT_D: begin
        rd_valid   = bus.mem_resp_valid;
        rd_data    = bus.mem_resp_data;
        resp_ready = bus.Read_data_Ready;
        if (bus.mem_resp_valid && bus.Read_data_Ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The state register only clears on the clock edge, so handshake outputs
    // are forced low for the whole time reset is asserted.
    if (rst) begin
      req_valid      = 1'b0;
      inst_req_ready = 1'b0;
      data_req_ready = 1'b0;
      inst_valid     = 1'b0;
      rd_valid       = 1'b0;
    end
  end

  assign bus.mem_req_valid   = req_valid;
  assign bus.mem_req_addr    = req_addr;
  assign bus.mem_req_wen     = req_wen;
  assign bus.mem_req_wdata   = req_wdata;
  assign bus.mem_req_wstrb   = req_wstrb;
  assign bus.mem_resp_ready  = resp_ready;
  assign bus.Inst_Req_Ready  = inst_req_ready;
  assign bus.Instruction     = inst_data;
  assign bus.Inst_Valid      = inst_valid;
  assign bus.Mem_Req_Ready   = data_req_ready;
  assign bus.Read_data       = rd_data;
  assign bus.Read_data_Valid = rd_valid;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] inst_wait_q;
  logic [31:0] data_wait_q;
  logic        inst_stall;
  logic        data_stall;

  assign inst_stall = (bus.Inst_Req_Valid && !inst_req_ready) ||
                      ((state_q == WAIT_I) && !inst_valid);
  assign data_stall = (data_req && !data_req_ready) ||
                      ((state_q == WAIT_D) && !rd_valid);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_wait_q <= '0;
      data_wait_q <= '0;
    end else begin
      if (inst_stall) inst_wait_q <= inst_wait_q + 32'd1;
      if (data_stall) data_wait_q <= data_wait_q + 32'd1;
    end
  end

  assign arb_inst_wait = rst ? '0 : inst_wait_q;
  assign arb_data_wait = rst ? '0 : data_wait_q;
`else
  assign arb_inst_wait = '0;
  assign arb_data_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further time unit later, well away from the clock edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] arb_inst_wait;
  logic [31:0] arb_data_wait;
  int unsigned n_checks;
  int unsigned n_fail;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .arb_inst_wait (arb_inst_wait),
    .arb_data_wait (arb_data_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.PC              = '0;
    bus.Inst_Req_Valid  = 1'b0;
    bus.Inst_Ready      = 1'b0;
    bus.Address         = '0;
    bus.MemWrite        = 1'b0;
    bus.MemRead         = 1'b0;
    bus.Write_data      = '0;
    bus.Write_strb      = '0;
    bus.Read_data_Ready = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_resp_valid  = 1'b0;
    bus.mem_resp_data   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();

    // ---------------- reset state ----------------
    step();
    bus.Inst_Req_Valid = 1'b1;
    bus.MemRead        = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    settle();
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_inst_rdy", bus.Inst_Req_Ready, 0);
    check("rst_mem_rdy", bus.Mem_Req_Ready, 0);
    check("rst_inst_vld", bus.Inst_Valid, 0);
    check("rst_rd_vld", bus.Read_data_Valid, 0);
    check("rst_resp_rdy", bus.mem_resp_ready, 1);
    check("rst_inst_cnt", arb_inst_wait, 0);
    check("rst_data_cnt", arb_data_wait, 0);
    do_reset();

    // ---------------- fetch ----------------
    bus.PC             = 32'h100;
    bus.Inst_Req_Valid = 1'b1;
    bus.Inst_Ready     = 1'b1;
    bus.mem_req_ready  = 1'b1;
    settle();
    check("f_valid", bus.mem_req_valid, 1);
    check("f_addr", bus.mem_req_addr, 32'h100);
    check("f_wen", bus.mem_req_wen, 0);
    check("f_wstrb", bus.mem_req_wstrb, 0);
    check("f_inst_rdy", bus.Inst_Req_Ready, 1);
    check("f_mem_rdy", bus.Mem_Req_Ready, 0);
    step();
    bus.Inst_Req_Valid = 1'b0;
    settle();
    check("f_wait_valid", bus.mem_req_valid, 0);
    check("f_wait_ivld", bus.Inst_Valid, 0);
    step();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h00000013;
    settle();
    check("f_ivld", bus.Inst_Valid, 1);
    check("f_inst", bus.Instruction, 32'h00000013);
    check("f_rdvld", bus.Read_data_Valid, 0);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.MemRead        = 1'b1;
    bus.Address        = 32'h10;
    settle();
    check("f_idle_req", bus.mem_req_valid, 1);
    check("f_idle_ivld", bus.Inst_Valid, 0);
`ifdef ARB_PERF_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    check("f_inst_cnt", arb_inst_wait, exp_cnt);
    do_reset();

    // ---------------- collision ----------------
    bus.PC              = 32'h300;
    bus.Inst_Req_Valid  = 1'b1;
    bus.Inst_Ready      = 1'b1;
    bus.MemRead         = 1'b1;
    bus.Address         = 32'h200;
    bus.Read_data_Ready = 1'b1;
    bus.mem_req_ready   = 1'b1;
    settle();
    check("c_addr", bus.mem_req_addr, 32'h200);
    check("c_mem_rdy", bus.Mem_Req_Ready, 1);
    check("c_inst_rdy", bus.Inst_Req_Ready, 0);
    step();
    bus.MemRead        = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFEF00D;
    settle();
    check("c_rdvld", bus.Read_data_Valid, 1);
    check("c_rdata", bus.Read_data, 32'hCAFEF00D);
    check("c_ivld0", bus.Inst_Valid, 0);
    check("c_wd_valid", bus.mem_req_valid, 0);
    check("c_wd_irdy", bus.Inst_Req_Ready, 0);
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    check("c_b2b_valid", bus.mem_req_valid, 1);
    check("c_b2b_addr", bus.mem_req_addr, 32'h300);
    check("c_b2b_irdy", bus.Inst_Req_Ready, 1);
    step();
    bus.Inst_Req_Valid = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h00000055;
    settle();
    check("c_ivld", bus.Inst_Valid, 1);
    check("c_inst", bus.Instruction, 32'h00000055);
    check("c_rdvld0", bus.Read_data_Valid, 0);
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
`ifdef ARB_PERF_CNT_EN
    exp_cnt = 32'd2;
`else
    exp_cnt = 32'd0;
`endif
    check("c_inst_cnt", arb_inst_wait, exp_cnt);
    check("c_data_cnt", arb_data_wait, 0);
    do_reset();

    // ---------------- store ----------------
    bus.MemWrite      = 1'b1;
    bus.Address       = 32'h40;
    bus.Write_data    = 32'hAABBCCDD;
    bus.Write_strb    = 4'b0100;
    bus.mem_req_ready = 1'b1;
    settle();
    check("s_valid", bus.mem_req_valid, 1);
    check("s_wen", bus.mem_req_wen, 1);
    check("s_addr", bus.mem_req_addr, 32'h40);
    check("s_wdata", bus.mem_req_wdata, 32'hAABBCCDD);
    check("s_wstrb", bus.mem_req_wstrb, 32'h4);
    check("s_mem_rdy", bus.Mem_Req_Ready, 1);
    step();
    bus.MemWrite       = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h11111111;
    settle();
    check("s_idle_rresp", bus.mem_resp_ready, 1);
    check("s_stray_rd", bus.Read_data_Valid, 0);
    check("s_stray_i", bus.Inst_Valid, 0);
    bus.mem_resp_valid = 1'b0;
    bus.Inst_Req_Valid = 1'b1;
    bus.PC             = 32'h500;
    settle();
    check("s_next_irdy", bus.Inst_Req_Ready, 1);
    do_reset();

    // ---------------- backpressure ----------------
    bus.MemRead       = 1'b1;
    bus.Address       = 32'h80;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("b_hold_valid", bus.mem_req_valid, 1);
      check("b_hold_addr", bus.mem_req_addr, 32'h80);
      check("b_hold_rdy", bus.Mem_Req_Ready, 0);
      step();
    end
    bus.mem_req_ready = 1'b1;
    settle();
    check("b_grant", bus.Mem_Req_Ready, 1);
    step();
    bus.mem_req_ready   = 1'b0;
    bus.mem_resp_valid  = 1'b1;
    bus.mem_resp_data   = 32'h12345678;
    bus.Read_data_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("b_resp_vld", bus.Read_data_Valid, 1);
      check("b_resp_data", bus.Read_data, 32'h12345678);
      check("b_resp_rdy", bus.mem_resp_ready, 0);
      step();
    end
    bus.MemRead         = 1'b0;
    bus.Read_data_Ready = 1'b1;
    settle();
    check("b_hs_rdy", bus.mem_resp_ready, 1);
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
`ifdef ARB_PERF_CNT_EN
    exp_cnt = 32'd8;
`else
    exp_cnt = 32'd0;
`endif
    check("b_data_cnt", arb_data_wait, exp_cnt);
    check("b_inst_cnt", arb_inst_wait, 0);
    do_reset();

    // ---------------- reset in WAIT_D ----------------
    bus.MemRead       = 1'b1;
    bus.Address       = 32'h90;
    bus.mem_req_ready = 1'b1;
    settle();
    check("r_grant", bus.Mem_Req_Ready, 1);
    step();
    bus.MemRead         = 1'b0;
    bus.Read_data_Ready = 1'b0;
    settle();
    check("r_waitd_rr", bus.mem_resp_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_resp_valid  = 1'b1;
    bus.mem_resp_data   = 32'h0000DEAD;
    bus.Read_data_Ready = 1'b1;
    settle();
    check("r_late_rdvld", bus.Read_data_Valid, 0);
    check("r_late_rr", bus.mem_resp_ready, 1);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.Inst_Req_Valid = 1'b1;
    bus.Inst_Ready     = 1'b1;
    bus.PC             = 32'h104;
    settle();
    check("r_f_addr", bus.mem_req_addr, 32'h104);
    check("r_f_irdy", bus.Inst_Req_Ready, 1);
    step();
    bus.Inst_Req_Valid = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h00000093;
    settle();
    check("r_f_ivld", bus.Inst_Valid, 1);
    check("r_f_inst", bus.Instruction, 32'h00000093);
    check("r_f_rdvld", bus.Read_data_Valid, 0);
    step();
    bus.mem_resp_valid = 1'b0;
    settle();
    check("r_end_idle", bus.mem_resp_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all address and data paths are 32 bits and the strobe is 4 bits.
REQ-002 SHALL have a single clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 PC  in  32  CPU instruction fetch address.
REQ-006 Inst_Req_Valid / Inst_Req_Ready  in / out  1  CPU instruction request handshake.
REQ-007 Instruction / Inst_Valid / Inst_Ready  out / out / in  32/1/1  CPU instruction response channel.
REQ-008 Address / MemWrite / MemRead  in  32/1/1  CPU data request, word-aligned address.
REQ-009 Write_data / Write_strb  in  32/4  CPU store data and byte strobes.
REQ-010 Mem_Req_Ready  out  1  CPU data request accepted.
REQ-011 Read_data / Read_data_Valid / Read_data_Ready  out / out / in  32/1/1  CPU load response channel.
REQ-012 mem_req_valid / mem_req_ready  out / in  1  unified memory request handshake.
REQ-013 mem_req_addr / mem_req_wen  out  32/1  memory address and write enable (1 = write).
REQ-014 mem_req_wdata / mem_req_wstrb  out  32/4  memory write data and strobes.
REQ-015 mem_resp_valid / mem_resp_ready / mem_resp_data  in / out / in  1/1/32  memory read response channel.
REQ-016 arb_inst_wait / arb_data_wait  out  32  stall counters; present only as described in Configuration.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, WAIT_I, WAIT_D.
REQ-018 IDLE: mem_req_valid = Inst_Req_Valid | MemRead | MemWrite.
REQ-019 IDLE grant: data (MemRead or MemWrite) has priority over instruction, fixed and non-rotating.
REQ-020 Data grant: mem_req_addr = Address, mem_req_wen = MemWrite, wdata/wstrb = Write_data/Write_strb.
REQ-021 Instruction grant: mem_req_addr = PC, mem_req_wen = 0, mem_req_wstrb = 0.
REQ-022 IDLE: Mem_Req_Ready = mem_req_ready & data granted; Inst_Req_Ready = mem_req_ready & instruction granted; the two are never both 1.
REQ-023 Outside IDLE: mem_req_valid, Inst_Req_Ready and Mem_Req_Ready SHALL be 0.
REQ-024 Transitions on a request handshake: instruction -> WAIT_I; MemRead -> WAIT_D; MemWrite -> IDLE, with no response phase.
REQ-025 WAIT_I: Inst_Valid = mem_resp_valid, Instruction = mem_resp_data, mem_resp_ready = Inst_Ready; on handshake -> IDLE.
REQ-026 WAIT_D: Read_data_Valid = mem_resp_valid, Read_data = mem_resp_data, mem_resp_ready = Read_data_Ready; on handshake -> IDLE.
REQ-027 Response valid SHALL reach only the channel that issued the request; the other response valid stays 0.
REQ-028 IDLE: mem_resp_ready = 1, and any stray mem_resp_valid is discarded without forwarding.
REQ-029 At most one memory transaction outstanding; minimum read turnaround is request cycle + 1 response cycle.
REQ-030 Back-to-back: a new request may be granted in the first IDLE cycle after a response handshake.

Reset
REQ-031 While rst = 1: state = IDLE, counters = 0; all CPU-side ready/valid outputs and mem_req_valid = 0.
REQ-032 Reset mid-transaction (WAIT_I/WAIT_D) SHALL abandon it; a late response is dropped per REQ-028.

Configuration
REQ-033 Macro ARB_PERF_CNT_EN defined: arb_inst_wait increments each cycle Inst_Req_Valid = 1 and Inst_Req_Ready = 0, or state = WAIT_I and Inst_Valid = 0.
REQ-034 With ARB_PERF_CNT_EN defined, arb_data_wait increments in the same way for the data channel (MemRead/MemWrite, WAIT_D, Read_data_Valid).
REQ-035 With ARB_PERF_CNT_EN defined, both counters wrap modulo 2^32.
REQ-036 Without ARB_PERF_CNT_EN: both counter outputs are constant 0 and no counter registers exist.

Verification
REQ-037 Fetch: PC=0x100, mem_req_ready=1, 2-cycle response 0x00000013 -> mem_req_addr=0x100, Inst_Valid with Instruction=0x00000013, FSM back to IDLE.
REQ-038 Collision: Inst_Req_Valid=1 and MemRead=1 with Address=0x200 in the same cycle -> data granted first (addr 0x200, Inst_Req_Ready=0); fetch granted after the load completes.
REQ-039 Store: MemWrite=1, Address=0x40, Write_data=0xAABBCCDD, strb=0100 -> one memory write with mem_req_wen=1; same-cycle Mem_Req_Ready; no response phase; IDLE next cycle.
REQ-040 Backpressure: mem_req_ready held 0 for 5 cycles, then Read_data_Ready=0 for 3 cycles with mem_resp_valid=1 -> request stays stable; response held; arb_data_wait=8 with ARB_PERF_CNT_EN.
REQ-041 Reset in WAIT_D followed by a late mem_resp_valid -> response dropped, Read_data_Valid stays 0, next fetch proceeds normally.
